// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment capture block.
package sseg_pkg;

  localparam int         DIGITS     = 8;
  localparam logic [7:0] ANODE_NONE = 8'hFF;

  typedef logic [7:0] seg_t;
  typedef seg_t [DIGITS-1:0] digit_arr_t;

  // Result of scanning an active-low anode vector.
  typedef struct packed {
    logic       ok;     // exactly one anode low
    logic       multi;  // two or more anodes low
    logic [2:0] idx;    // index of the low anode when ok
  } an_dec_t;

  function automatic an_dec_t onehot0_idx(input logic [DIGITS-1:0] an);
    an_dec_t     res;
    int unsigned zeros;
    res   = '0;
    zeros = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        zeros++;
        res.idx = 3'(i);
      end
    end
    res.ok    = (zeros == 1);
    res.multi = (zeros > 1);
    return res;
  endfunction

endpackage

// File: rtl/sseg_stable_det.sv
// Input register plus stability filter: raises cap for one cycle once the
// registered bus has held the same value for SETTLE consecutive compares.
module sseg_stable_det #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         cap
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [W-1:0] in_q;
  logic [W-1:0] in_p;
  logic [3:0]   stab_q;
  logic [3:0]   stab_d;
  logic         same;

  // Register the pins and keep the previous sample; all-ones after reset
  // looks like a blank interval so the first real sample starts a new window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_q <= '1;
      in_p <= '1;
    end else begin
      in_q <= din;
      in_p <= in_q;
    end
  end

  // Stability counter state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end

  // Count equal compares, saturating at SETTLE; any change restarts.
  always_comb begin
    same   = (in_q == in_p);
    stab_d = stab_q;
    if (!same) begin
      stab_d = '0;
    end else if (stab_q < SETTLE_C) begin
      stab_d = stab_q + 4'd1;
    end
  end

  // Single strobe on the SETTLE-1 -> SETTLE step of each stable window.
  assign cap  = same && (stab_q == (SETTLE_C - 4'd1));
  assign dout = in_q;

endmodule

// File: rtl/sseg_capture8.sv
// Rebuilds eight digit patterns from a multiplexed active-low anode/segment
// bus, with per-digit staleness timeout, change pulses and a bus-error flag.
module sseg_capture8
  import sseg_pkg::*;
#(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic [7:0] valid,
  output logic [7:0] chg,
  output logic       err_multi
);

  localparam logic [TIMEOUT_W-1:0] AGE_MAX = '1;

  logic [15:0]          in_q;
  logic                 cap;
  an_dec_t              dec;
  seg_t                 new_seg;

  digit_arr_t           dig_q;
  digit_arr_t           dig_d;
  logic [DIGITS-1:0]    valid_q;
  logic [DIGITS-1:0]    valid_d;
  logic [DIGITS-1:0]    chg_q;
  logic [DIGITS-1:0]    chg_d;
  logic                 err_q;
  logic                 err_d;
  logic [TIMEOUT_W-1:0] age_q [DIGITS];
  logic [TIMEOUT_W-1:0] age_d [DIGITS];

  sseg_stable_det #(
    .SETTLE (SETTLE),
    .W      (16)
  ) u_stable (
    .clk   (clk),
    .reset (reset),
    .din   ({an, sseg}),
    .dout  (in_q),
    .cap   (cap)
  );

  assign dec     = onehot0_idx(in_q[15:8]);
  assign new_seg = ~in_q[7:0];

  // Next-state: age/timeout for every digit, then a capture overrides its digit.
  always_comb begin
    dig_d   = dig_q;
    valid_d = valid_q;
    chg_d   = '0;
    err_d   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      age_d[i] = age_q[i];
      if (valid_q[i]) begin
        if (age_q[i] == AGE_MAX) begin
          valid_d[i] = 1'b0;
        end else begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
    if (cap && (in_q[15:8] != ANODE_NONE)) begin
      if (dec.ok) begin
        dig_d[dec.idx]   = new_seg;
        valid_d[dec.idx] = 1'b1;
        age_d[dec.idx]   = '0;
        chg_d[dec.idx]   = (new_seg != dig_q[dec.idx]) || !valid_q[dec.idx];
      end else if (dec.multi) begin
        err_d = 1'b1;
      end
    end
  end

  // Digit, validity, age and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dig_q   <= '0;
      valid_q <= '0;
      chg_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      dig_q   <= dig_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
      for (int i = 0; i < DIGITS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign out0      = dig_q[0];
  assign out1      = dig_q[1];
  assign out2      = dig_q[2];
  assign out3      = dig_q[3];
  assign out4      = dig_q[4];
  assign out5      = dig_q[5];
  assign out6      = dig_q[6];
  assign out7      = dig_q[7];
  assign valid     = valid_q;
  assign chg       = chg_q;
  assign err_multi = err_q;

endmodule

// File: tb/tb_sseg_capture8.sv
// Bench for sseg_capture8: directed scenarios plus random bus traffic, checked
// against a run-length reference model with a pulse scoreboard.
module tb_sseg_capture8;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TW      = 6;
  localparam int          AGE_MAX = (1 << TW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] an;
  logic [7:0] sseg;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0] valid;
  logic [7:0] chg;
  logic       err_multi;

  sseg_capture8 #(
    .SETTLE    (SETTLE),
    .TIMEOUT_W (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .sseg      (sseg),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .valid     (valid),
    .chg       (chg),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] chg;
    logic       err;
  } ev_t;

  ev_t evq[$];
  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  cyc      = 0;
  bit  checking = 1'b0;

  // Reference model state.
  logic [7:0]  m_out [8];
  logic [7:0]  m_valid;
  int          m_age [8];
  logic [15:0] run_val;
  int          run;
  bit          pend;
  logic [15:0] pend_val;

  // One rising edge of the model. A capture happens on the edge after the
  // sampled bus value has been seen SETTLE+1 times in a row.
  task automatic model_edge(input logic r, input logic [15:0] smp);
    logic [7:0] vb;
    logic [7:0] a;
    logic [7:0] nv;
    int         zeros;
    int         idx;
    ev_t        e;
    if (!r) begin
      for (int i = 0; i < 8; i++) begin
        m_out[i] = 8'h00;
        m_age[i] = 0;
      end
      m_valid = 8'h00;
      run_val = 16'hFFFF;
      run     = 1;
      pend    = 1'b0;
      return;
    end
    vb = m_valid;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i]) begin
        if (m_age[i] == AGE_MAX) m_valid[i] = 1'b0;
        else m_age[i]++;
      end
    end
    if (pend) begin
      a     = pend_val[15:8];
      nv    = ~pend_val[7:0];
      zeros = 8 - $countones(a);
      idx   = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
      e.cyc = cyc;
      e.chg = 8'h00;
      e.err = 1'b0;
      if (zeros == 1) begin
        e.chg[idx]   = (nv != m_out[idx]) || !vb[idx];
        m_out[idx]   = nv;
        m_valid[idx] = 1'b1;
        m_age[idx]   = 0;
      end else if (zeros > 1) begin
        e.err = 1'b1;
      end
      if (e.chg != 8'h00 || e.err) evq.push_back(e);
    end
    if (smp == run_val) begin
      run++;
    end else begin
      run_val = smp;
      run     = 1;
    end
    pend     = (run == SETTLE + 1);
    pend_val = smp;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n, input logic r);
    for (int k = 0; k < n; k++) begin
      #1;
      an    = a;
      sseg  = s;
      reset = r;
      @(posedge clk);
      cyc++;
      model_edge(r, {a, s});
      checking = 1'b1;
    end
  endtask

  // Monitor: full state every cycle, pulses against the scoreboard queue.
  logic [63:0] exp_all;
  logic [63:0] dut_all;
  ev_t         me;
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 8; i++) exp_all[i*8 +: 8] = m_out[i];
      dut_all = {out7, out6, out5, out4, out3, out2, out1, out0};
      n_cmp++;
      if (valid !== m_valid || dut_all !== exp_all) begin
        n_bad++;
        $display("FAIL state cyc=%0d valid=%h want %h outs=%h want %h",
                 cyc, valid, m_valid, dut_all, exp_all);
      end
      if (chg !== 8'h00 || err_multi !== 1'b0) begin
        n_cmp++;
        if (evq.size() == 0) begin
          n_bad++;
          $display("FAIL pulse cyc=%0d got chg=%h err=%b want no pulse", cyc, chg, err_multi);
        end else begin
          me = evq.pop_front();
          if (me.cyc != cyc || me.chg !== chg || me.err !== err_multi) begin
            n_bad++;
            $display("FAIL pulse cyc=%0d got chg=%h err=%b want cyc=%0d chg=%h err=%b",
                     cyc, chg, err_multi, me.cyc, me.chg, me.err);
          end
        end
      end
    end
  end

  logic [7:0] pat [8];
  logic [7:0] pool [4];
  logic [7:0] ra;
  logic [7:0] rs;
  int         kind;

  initial begin
    reset = 1'b0;
    an    = 8'h00;
    sseg  = 8'h00;
    pat   = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    pool  = '{8'h06, 8'h5B, 8'h3F, 8'h00};

    // Reset, then idle blank bus.
    drive(8'h00, 8'h00, 3, 1'b0);
    drive(8'hFF, 8'h00, 100, 1'b1);

    // Single capture of digit 2.
    drive(8'hFB, 8'hC0, 10, 1'b1);

    // Two identical full scans; the second lands on each digit's timeout edge.
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 8; d++) begin
        ra = ~(8'h01 << d);
        drive(ra, ~pat[d], 8, 1'b1);
      end
    end

    // Glitch shorter than a window, then a real change.
    drive(8'hFD, ~8'h06, 8, 1'b1);
    drive(8'hFD, ~8'h5B, 3, 1'b1);
    drive(8'hFD, ~8'h06, 8, 1'b1);
    drive(8'hFD, ~8'h5B, 6, 1'b1);

    // Two anodes low.
    drive(8'hFC, 8'h55, 6, 1'b1);
    drive(8'hFF, 8'hFF, 3, 1'b1);

    // Timeout and capture on the timeout edge (same value, then new value).
    drive(8'hFF, 8'hFF, 80, 1'b1);
    drive(8'hFE, ~8'h3F, 6, 1'b1);
    drive(8'hFF, 8'hFF, 58, 1'b1);
    drive(8'hFE, ~8'h3F, 8, 1'b1);
    drive(8'hFF, 8'hFF, 80, 1'b1);
    drive(8'hFE, ~8'h3F, 6, 1'b1);
    drive(8'hFF, 8'hFF, 58, 1'b1);
    drive(8'hFE, ~8'h06, 8, 1'b1);

    // Reset in the middle of a stable window.
    drive(8'hF7, ~8'h4F, 3, 1'b1);
    drive(8'hF7, ~8'h4F, 1, 1'b0);
    drive(8'hF7, ~8'h4F, 8, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      rs   = ($urandom_range(0, 1) == 0) ? ~pool[$urandom_range(0, 3)] : 8'($urandom);
      if (kind <= 6) begin
        ra = ~(8'h01 << $urandom_range(0, 7));
      end else if (kind == 7) begin
        ra = 8'hFF;
      end else begin
        ra = 8'($urandom) & ~(8'h03 << $urandom_range(0, 6));
      end
      if (kind == 9 && $urandom_range(0, 9) == 0) begin
        drive(ra, rs, $urandom_range(1, 2), 1'b0);
      end else begin
        drive(ra, rs, $urandom_range(1, 9), 1'b1);
      end
    end

    drive(8'hFF, 8'hFF, 20, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (evq.size() != 0) begin
      n_bad++;
      $display("FAIL pending_pulses got %0d outstanding want 0", evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
